// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO helpers: default geometry and Gray/binary conversion.
// Used by both the write-side and read-side pointer handlers.
package fifo_pkg;

  localparam int unsigned FIFO_PTR_MAX = 16;
  localparam int unsigned FIFO_PTR_WD  = 10;
  localparam int unsigned FIFO_DEPTH   = 1024;

  typedef logic [FIFO_PTR_MAX-1:0] fifo_ptr_t;

  // Binary to reflected Gray code
  function automatic fifo_ptr_t bin2gray(input fifo_ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: bit i is the XOR of all Gray bits from the top down to i
  function automatic fifo_ptr_t gray2bin(input fifo_ptr_t g);
    fifo_ptr_t b;
    b[FIFO_PTR_MAX-1] = g[FIFO_PTR_MAX-1];
    for (int i = int'(FIFO_PTR_MAX) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_handler_if.sv
// Write-side pointer handler bus: write handshake, read pointer input, pointers and flags.
interface wptr_handler_if
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_WD = FIFO_PTR_WD
);

  localparam int unsigned PW = PTR_WD + 1;

  logic          w_en_i;
  logic [PW-1:0] g_rptr_i;
  logic          w_ack_o;
  logic [PW-1:0] b_wptr_o;
  logic [PW-1:0] g_wptr_o;
  logic [PW-1:0] data_cnt_w;
  logic          full_o;
  logic          afull_o;
  logic          ovf_o;

  // FIFO write client / read-domain pointer source
  modport master (
    output w_en_i, g_rptr_i,
    input  w_ack_o, b_wptr_o, g_wptr_o, data_cnt_w, full_o, afull_o, ovf_o
  );

  // Pointer handler
  modport slave (
    input  w_en_i, g_rptr_i,
    output w_ack_o, b_wptr_o, g_wptr_o, data_cnt_w, full_o, afull_o, ovf_o
  );

endinterface

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Synchronous active-high reset; no logic is placed between the flops.
module ptr_sync_2ff #(
  parameter int unsigned WD = 11
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [WD-1:0] d_i,
  output logic [WD-1:0] q_o
);

  logic [WD-1:0] meta_q;
  logic [WD-1:0] sync_q;

  // Two-stage capture of the asynchronous pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/wptr_handler.sv
// Write-side pointer and flag logic of the dual-clock FIFO.
// Advances binary/Gray write pointers, synchronizes the read Gray pointer and
// derives full, almost-full and write-side occupancy.
// Optional feature macro: WPTR_OVF_FLAG_EN enables the sticky overflow flag ovf_o;
// when undefined ovf_o is tied low and no register is built.
module wptr_handler
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_WD    = FIFO_PTR_WD,
  parameter int unsigned DEPTH     = FIFO_DEPTH,
  parameter int unsigned AFULL_THR = 1016
) (
  input  logic           w_clk_i,
  input  logic           w_rst_i,
  wptr_handler_if.slave  bus
);

  localparam int unsigned PW = PTR_WD + 1;
  localparam logic [PW-1:0] AFULL_V = PW'(AFULL_THR);

  // Elaboration-time parameter sanity
  if (PTR_WD < 2 || PW > FIFO_PTR_MAX) begin : g_ptr_wd_chk
    $error("wptr_handler: PTR_WD out of range");
  end
  if (DEPTH != (32'd1 << PTR_WD)) begin : g_depth_chk
    $error("wptr_handler: DEPTH must equal 2**PTR_WD");
  end
  if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_afull_chk
    $error("wptr_handler: AFULL_THR must be in 1..DEPTH");
  end

  logic [PW-1:0] b_wptr_q, b_wptr_d;
  logic [PW-1:0] g_wptr_q, g_wptr_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic [PW-1:0] g_rptr_sync;
  logic [PW-1:0] b_rptr_sync;
  logic [PW-1:0] g_full_cmp;
  logic [PW-1:0] occ_nxt;
  logic          w_ack;

  // Read Gray pointer into the write domain
  ptr_sync_2ff #(
    .WD (PW)
  ) u_rptr_sync (
    .clk_i (w_clk_i),
    .rst_i (w_rst_i),
    .d_i   (bus.g_rptr_i),
    .q_o   (g_rptr_sync)
  );

  // Accept, next pointers and flag evaluation
  always_comb begin
    w_ack       = bus.w_en_i & ~full_q;
    b_wptr_d    = b_wptr_q + PW'(w_ack);
    g_wptr_d    = PW'(bin2gray(fifo_ptr_t'(b_wptr_d)));
    b_rptr_sync = PW'(gray2bin(fifo_ptr_t'(g_rptr_sync)));
    g_full_cmp  = {~g_rptr_sync[PTR_WD:PTR_WD-1], g_rptr_sync[PTR_WD-2:0]};
    occ_nxt     = b_wptr_d - b_rptr_sync;
    full_d      = (g_wptr_d == g_full_cmp);
    afull_d     = (occ_nxt >= AFULL_V);
  end

  // Pointer and flag registers
  always_ff @(posedge w_clk_i) begin
    if (w_rst_i) begin
      b_wptr_q <= '0;
      g_wptr_q <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      b_wptr_q <= b_wptr_d;
      g_wptr_q <= g_wptr_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
    end
  end

`ifdef WPTR_OVF_FLAG_EN
  logic ovf_q;

  // Sticky record of any write attempted while full
  always_ff @(posedge w_clk_i) begin
    if (w_rst_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (bus.w_en_i & full_q);
    end
  end

  assign bus.ovf_o = ovf_q;
`else
  assign bus.ovf_o = 1'b0;
`endif

  assign bus.w_ack_o    = w_ack;
  assign bus.b_wptr_o   = b_wptr_q;
  assign bus.g_wptr_o   = g_wptr_q;
  assign bus.full_o     = full_q;
  assign bus.afull_o    = afull_q;
  assign bus.data_cnt_w = b_wptr_q - b_rptr_sync;

endmodule

// File: tb/tb_wptr_handler.sv
// Directed bench for wptr_handler with PTR_WD=4, DEPTH=16, AFULL_THR=14.
module tb_wptr_handler;

  localparam int unsigned PTR_WD    = 4;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned AFULL_THR = 14;

`ifdef WPTR_OVF_FLAG_EN
  localparam int unsigned OVF_EXP = 1;
`else
  localparam int unsigned OVF_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wptr_handler_if #(.PTR_WD(PTR_WD)) bus ();

  wptr_handler #(
    .PTR_WD    (PTR_WD),
    .DEPTH     (DEPTH),
    .AFULL_THR (AFULL_THR)
  ) dut (
    .w_clk_i (clk),
    .w_rst_i (rst),
    .bus     (bus)
  );

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ {1'b0, b[4:1]};
  endfunction

  logic [4:0] wp, rp, rs1, rs2, wp_n, prev;
  logic       full_m, afull_m, a;
  int         acc, cyc;
  bit         wrapped;

  initial begin
    rst          = 1'b1;
    bus.w_en_i   = 1'b0;
    bus.g_rptr_i = '0;
    step();
    step();
    chk("rst_bwptr", 32'(bus.b_wptr_o), 0);
    chk("rst_gwptr", 32'(bus.g_wptr_o), 0);
    chk("rst_full",  32'(bus.full_o), 0);
    chk("rst_afull", 32'(bus.afull_o), 0);
    chk("rst_cnt",   32'(bus.data_cnt_w), 0);
    chk("rst_ovf",   32'(bus.ovf_o), 0);
    rst = 1'b0;

    // 1: fill to full
    bus.w_en_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk("t1_ack", 32'(bus.w_ack_o), 1);
      step();
      chk("t1_bwptr", 32'(bus.b_wptr_o), 32'(k));
      chk("t1_cnt",   32'(bus.data_cnt_w), 32'(k));
      chk("t1_afull", 32'(bus.afull_o), (k >= 14) ? 1 : 0);
      chk("t1_full",  32'(bus.full_o), (k == 16) ? 1 : 0);
    end
    chk("t1_gwptr", 32'(bus.g_wptr_o), 32'h18);

    // 2: write attempts while full
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t2_ack", 32'(bus.w_ack_o), 0);
      step();
      chk("t2_bwptr", 32'(bus.b_wptr_o), 16);
      chk("t2_full",  32'(bus.full_o), 1);
      chk("t2_ovf",   32'(bus.ovf_o), OVF_EXP);
    end

    // 3: reader frees 4 entries
    bus.w_en_i   = 1'b0;
    bus.g_rptr_i = 5'b00110;
    step();
    chk("t3_e1_full", 32'(bus.full_o), 1);
    chk("t3_e1_cnt",  32'(bus.data_cnt_w), 16);
    step();
    chk("t3_e2_full",  32'(bus.full_o), 1);
    chk("t3_e2_afull", 32'(bus.afull_o), 1);
    chk("t3_e2_cnt",   32'(bus.data_cnt_w), 12);
    step();
    chk("t3_e3_full",  32'(bus.full_o), 0);
    chk("t3_e3_afull", 32'(bus.afull_o), 0);
    chk("t3_e3_cnt",   32'(bus.data_cnt_w), 12);

    // 4: 13 then 14 entries
    bus.w_en_i = 1'b1;
    for (int k = 13; k <= 14; k++) begin
      #1;
      chk("t4_ack", 32'(bus.w_ack_o), 1);
      step();
      chk("t4_cnt",   32'(bus.data_cnt_w), 32'(k));
      chk("t4_afull", 32'(bus.afull_o), (k == 14) ? 1 : 0);
      chk("t4_full",  32'(bus.full_o), 0);
    end

    // 5: wrap with a model reader advancing every third cycle
    wp = 5'd18; rp = 5'd4; rs1 = 5'd4; rs2 = 5'd4;
    full_m = 1'b0; afull_m = 1'b1;
    acc = 0; cyc = 0; wrapped = 0;
    while (acc < 40 && cyc < 400) begin
      if ((cyc % 3) == 0 && rp != wp) rp = rp + 5'd1;
      bus.g_rptr_i = gray5(rp);
      bus.w_en_i   = 1'b1;
      #1;
      a = ~full_m;
      chk("t5_ack", 32'(bus.w_ack_o), 32'(a));
      prev    = wp;
      wp_n    = wp + 5'(a);
      full_m  = ((wp_n - rs2) == 5'd16);
      afull_m = ((wp_n - rs2) >= 5'd14);
      rs2     = rs1;
      rs1     = rp;
      wp      = wp_n;
      if (a) acc++;
      step();
      chk("t5_bwptr", 32'(bus.b_wptr_o), 32'(wp));
      chk("t5_full",  32'(bus.full_o), 32'(full_m));
      chk("t5_afull", 32'(bus.afull_o), 32'(afull_m));
      chk("t5_cnt",   32'(bus.data_cnt_w), 32'(5'(wp - rs2)));
      if (prev == 5'd31 && wp == 5'd0) wrapped = 1;
      cyc++;
    end
    chk("t5_accepts", 32'(acc), 40);
    chk("t5_wrapped", 32'(wrapped), 1);

    // 6: top up to full, drain to 9 entries, then reset
    bus.w_en_i = 1'b1;
    repeat (20) step();
    wp = rp + 5'd16;
    chk("t6_full_bwptr", 32'(bus.b_wptr_o), 32'(wp));
    chk("t6_full",       32'(bus.full_o), 1);
    bus.w_en_i   = 1'b0;
    rp           = wp - 5'd9;
    bus.g_rptr_i = gray5(rp);
    repeat (3) step();
    chk("t6_cnt9",   32'(bus.data_cnt_w), 9);
    chk("t6_full9",  32'(bus.full_o), 0);
    chk("t6_afull9", 32'(bus.afull_o), 0);
    chk("t6_ovf9",   32'(bus.ovf_o), OVF_EXP);
    rst          = 1'b1;
    bus.g_rptr_i = '0;
    step();
    rst = 1'b0;
    chk("t6_bwptr", 32'(bus.b_wptr_o), 0);
    chk("t6_gwptr", 32'(bus.g_wptr_o), 0);
    chk("t6_full",  32'(bus.full_o), 0);
    chk("t6_afull", 32'(bus.afull_o), 0);
    chk("t6_ovf",   32'(bus.ovf_o), 0);
    chk("t6_cnt",   32'(bus.data_cnt_w), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
